// File: rtl/treeval_msg_pkg.sv
// Shared types for the P2P NoC message responder:
// message layouts, opcodes, status codes and FSM states.
package treeval_msg_pkg;

  localparam int W_MSG  = 64;
  localparam int W_DATA = 32;

  typedef enum logic [3:0] {
    OP_WRITE = 4'h1,
    OP_READ  = 4'h2,
    OP_ADD   = 4'h3,
    OP_PING  = 4'hF
  } op_e;

  localparam logic [3:0] ST_OK  = 4'hA;
  localparam logic [3:0] ST_ERR = 4'hE;

  typedef struct packed {
    logic [3:0]        op;
    logic [3:0]        rsv0;
    logic [7:0]        tag;
    logic [7:0]        addr;
    logic [7:0]        rsv1;
    logic [W_DATA-1:0] data;
  } req_t;

  typedef struct packed {
    logic [3:0]        status;
    logic [3:0]        op;
    logic [7:0]        tag;
    logic [7:0]        addr;
    logic [7:0]        rsv;
    logic [W_DATA-1:0] rdata;
  } resp_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    SEND
  } state_e;

endpackage

// File: rtl/msg_responder_regfile.sv
// Local register table: combinational read,
// single write port, cleared by reset.
module msg_responder_regfile
  import treeval_msg_pkg::*;
#(
  parameter int N_REG = 16,
  parameter int AW    = $clog2(N_REG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [W_DATA-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [W_DATA-1:0] rdata_o
);

  logic [W_DATA-1:0] mem_q [N_REG];

  // Table storage, zeroed on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_REG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/msg_responder.sv
// Compute-side responder: pops request msgs, runs them
// against the register table, pushes one response each.
module msg_responder
  import treeval_msg_pkg::*;
#(
  parameter int N_REG = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_in_msg_rdy,
  input  logic [W_MSG-1:0] i_in_msg,
  output logic             i_in_msg_ack,
  output logic             i_out_msg_rdy,
  output logic [W_MSG-1:0] i_out_msg,
  input  logic             i_out_msg_ack,
  output logic             busy,
  output logic [15:0]      req_count,
  output logic [7:0]       err_count
);

  localparam int AW = $clog2(N_REG);
  localparam logic [8:0] NREG9 = 9'(N_REG);

  state_e            state_q;
  req_t              req_q;
  req_t              in_req;
  resp_t             resp_q;
  resp_t             resp_d;
  logic              in_ack_q;
  logic              out_rdy_q;
  logic [15:0]       req_cnt_q;
  logic [7:0]        err_cnt_q;
  logic              addr_ok;
  logic              wr_req;
  logic              we;
  logic [W_DATA-1:0] wdata;
  logic [W_DATA-1:0] rd;
  logic [W_DATA-1:0] sum;
  logic              unused_ok;

  assign in_req = req_t'(i_in_msg);

  msg_responder_regfile #(
    .N_REG (N_REG)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we),
    .waddr_i (req_q.addr[AW-1:0]),
    .wdata_i (wdata),
    .raddr_i (req_q.addr[AW-1:0]),
    .rdata_o (rd)
  );

  assign sum = rd + req_q.data;

  // Decode the latched request into a response and table write
  always_comb begin
    resp_d        = '0;
    resp_d.status = ST_OK;
    resp_d.op     = req_q.op;
    resp_d.tag    = req_q.tag;
    resp_d.addr   = req_q.addr;
    wr_req        = 1'b0;
    wdata         = req_q.data;
    addr_ok       = {1'b0, req_q.addr} < NREG9;
    case (req_q.op)
      OP_WRITE: begin
        if (addr_ok) begin
          resp_d.rdata = rd;
          wr_req       = 1'b1;
        end else begin
          resp_d.status = ST_ERR;
        end
      end
      OP_READ: begin
        if (addr_ok) resp_d.rdata = rd;
        else         resp_d.status = ST_ERR;
      end
      OP_ADD: begin
        if (addr_ok) begin
          resp_d.rdata = sum;
          wr_req       = 1'b1;
          wdata        = sum;
        end else begin
          resp_d.status = ST_ERR;
        end
      end
      OP_PING: resp_d.rdata = req_q.data;
      default: resp_d.status = ST_ERR;
    endcase
  end

  assign we = wr_req && (state_q == EXEC);

  // Request/response FSM with registered handshakes and counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      req_q     <= '0;
      resp_q    <= '0;
      in_ack_q  <= 1'b0;
      out_rdy_q <= 1'b0;
      req_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_in_msg_rdy) begin
            req_q <= '{op:   in_req.op,
                       rsv0: 4'h0,
                       tag:  in_req.tag,
                       addr: in_req.addr,
                       rsv1: 8'h00,
                       data: in_req.data};
            in_ack_q <= 1'b1;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          in_ack_q  <= 1'b0;
          resp_q    <= resp_d;
          out_rdy_q <= 1'b1;
          state_q   <= SEND;
        end
        SEND: begin
          if (i_out_msg_ack) begin
            out_rdy_q <= 1'b0;
            req_cnt_q <= req_cnt_q + 16'd1;
            if (resp_q.status == ST_ERR && err_cnt_q != 8'hFF) begin
              err_cnt_q <= err_cnt_q + 8'd1;
            end
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i_in_msg_ack  = in_ack_q;
  assign i_out_msg_rdy = out_rdy_q;
  assign i_out_msg     = resp_q;
  assign busy          = (state_q != IDLE);
  assign req_count     = req_cnt_q;
  assign err_count     = err_cnt_q;

  assign unused_ok = ^{in_req.rsv0, in_req.rsv1,
                       req_q.rsv0, req_q.rsv1};

endmodule

// File: tb/tb_msg_responder.sv
// Directed bench for msg_responder: protocol timing,
// opcode semantics, errors, backpressure and reset.
module tb_msg_responder;
  import treeval_msg_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_in_msg_rdy;
  logic [63:0] i_in_msg;
  logic        i_in_msg_ack;
  logic        i_out_msg_rdy;
  logic [63:0] i_out_msg;
  logic        i_out_msg_ack;
  logic        busy;
  logic [15:0] req_count;
  logic [7:0]  err_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  msg_responder dut (
    .clk           (clk),
    .rst           (rst),
    .i_in_msg_rdy  (i_in_msg_rdy),
    .i_in_msg      (i_in_msg),
    .i_in_msg_ack  (i_in_msg_ack),
    .i_out_msg_rdy (i_out_msg_rdy),
    .i_out_msg     (i_out_msg),
    .i_out_msg_ack (i_out_msg_ack),
    .busy          (busy),
    .req_count     (req_count),
    .err_count     (err_count)
  );

  // Driver: offer one request, consume its response.
  task automatic do_req(input logic [63:0] m,
                        output logic [63:0] rsp,
                        output int ack_lat,
                        output int rsp_lat,
                        output bit to);
    @(negedge clk);
    i_in_msg     = m;
    i_in_msg_rdy = 1'b1;
    ack_lat      = -1;
    rsp_lat      = -1;
    to           = 1'b0;
    rsp          = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (i_in_msg_ack && ack_lat < 0) begin
        ack_lat      = c;
        i_in_msg_rdy = 1'b0;
      end
      if (i_out_msg_rdy) begin
        rsp_lat = c;
        rsp     = i_out_msg;
        break;
      end
    end
    i_in_msg_rdy = 1'b0;
    if (rsp_lat < 0) begin
      to = 1'b1;
    end else begin
      i_out_msg_ack = 1'b1;
      @(negedge clk);
      i_out_msg_ack = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst           = 1'b0;
    i_in_msg_rdy  = 1'b0;
    i_in_msg      = '0;
    i_out_msg_ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({i_in_msg_ack, i_out_msg_rdy, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got=%b want=000",
               {i_in_msg_ack, i_out_msg_rdy, busy});
    end
    checks++;
    if (i_out_msg !== 64'h0) begin
      errors++;
      $display("FAIL reset_out_msg got=%h want=0", i_out_msg);
    end
    checks++;
    if ({req_count, err_count} !== 24'h0) begin
      errors++;
      $display("FAIL reset_counts got=%h want=0",
               {req_count, err_count});
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || i_in_msg_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got=%b%b want=00",
               busy, i_in_msg_ack);
    end
  endtask

  task automatic test_write();
    logic [63:0] r;
    int al, rl;
    bit to;
    do_req(64'h1005_0300_DEADBEEF, r, al, rl, to);
    checks++;
    if (to || r !== 64'hA105_0300_0000_0000) begin
      errors++;
      $display("FAIL write_resp got=%h to=%0d want=a105030000000000",
               r, to);
    end
    checks++;
    if (al !== 1 || rl !== 2) begin
      errors++;
      $display("FAIL write_latency got=ack%0d/rsp%0d want=ack1/rsp2",
               al, rl);
    end
    checks++;
    if (req_count !== 16'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL write_count got=%0d busy=%b want=1 busy=0",
               req_count, busy);
    end
  endtask

  task automatic test_read_add();
    logic [63:0] req [5];
    logic [63:0] exp [5];
    logic [63:0] r;
    int al, rl;
    bit to;
    req[0] = 64'h2006_0300_0000_0000;
    exp[0] = 64'hA206_0300_DEADBEEF;
    req[1] = 64'h1007_0500_FFFFFFFF;
    exp[1] = 64'hA107_0500_0000_0000;
    req[2] = 64'h3008_0500_0000_0002;
    exp[2] = 64'hA308_0500_0000_0001;
    req[3] = 64'h2009_0500_0000_0000;
    exp[3] = 64'hA209_0500_0000_0001;
    req[4] = 64'h2A0A_05FF_12345678;
    exp[4] = 64'hA20A_0500_0000_0001;
    for (int i = 0; i < 5; i++) begin
      do_req(req[i], r, al, rl, to);
      checks++;
      if (to || r !== exp[i]) begin
        errors++;
        $display("FAIL rd_add_%0d got=%h to=%0d want=%h",
                 i, r, to, exp[i]);
      end
    end
    checks++;
    if (req_count !== 16'd6 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL rd_add_counts got=%0d/%0d want=6/0",
               req_count, err_count);
    end
  endtask

  task automatic test_errors();
    logic [63:0] req [5];
    logic [63:0] exp [5];
    logic [63:0] r;
    int al, rl;
    bit to;
    req[0] = 64'h700B_0300_11111111;
    exp[0] = 64'hE70B_0300_0000_0000;
    req[1] = 64'h100C_2000_55555555;
    exp[1] = 64'hE10C_2000_0000_0000;
    req[2] = 64'h200E_1000_0000_0000;
    exp[2] = 64'hE20E_1000_0000_0000;
    req[3] = 64'h200F_0300_0000_0000;
    exp[3] = 64'hA20F_0300_DEADBEEF;
    req[4] = 64'hF00D_2000_CAFEF00D;
    exp[4] = 64'hAF0D_2000_CAFEF00D;
    for (int i = 0; i < 5; i++) begin
      do_req(req[i], r, al, rl, to);
      checks++;
      if (to || r !== exp[i]) begin
        errors++;
        $display("FAIL err_%0d got=%h to=%0d want=%h",
                 i, r, to, exp[i]);
      end
      if (i == 0) begin
        checks++;
        if (err_count !== 8'd1 || req_count !== 16'd7) begin
          errors++;
          $display("FAIL err_first got=%0d/%0d want=7/1",
                   req_count, err_count);
        end
      end
    end
    checks++;
    if (req_count !== 16'd11 || err_count !== 8'd3) begin
      errors++;
      $display("FAIL err_counts got=%0d/%0d want=11/3",
               req_count, err_count);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] held;
    int acks;
    int unstable;
    bit seen;
    @(negedge clk);
    i_in_msg     = 64'h2010_0300_0000_0000;
    i_in_msg_rdy = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (i_in_msg_ack) begin
        seen     = 1'b1;
        i_in_msg = 64'hF011_0000_0000_0042;
      end
    end
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = i_out_msg_rdy;
    end
    held = i_out_msg;
    checks++;
    if (!seen || held !== 64'hA210_0300_DEADBEEF) begin
      errors++;
      $display("FAIL bp_resp got=%h want=a2100300deadbeef", held);
    end
    acks = 0;
    unstable = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (i_in_msg_ack) acks++;
      if (!i_out_msg_rdy || i_out_msg !== held) unstable++;
    end
    checks++;
    if (acks !== 0 || unstable !== 0) begin
      errors++;
      $display("FAIL bp_hold got=acks%0d/unstable%0d want=0/0",
               acks, unstable);
    end
    i_out_msg_ack = 1'b1;
    @(negedge clk);
    i_out_msg_ack = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 5 && !seen; c++) begin
      @(negedge clk);
      if (i_in_msg_ack) begin
        seen = 1'b1;
        i_in_msg_rdy = 1'b0;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL bp_next_pop got=no_ack want=ack");
    end
    i_in_msg_rdy = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = i_out_msg_rdy;
    end
    checks++;
    if (!seen || i_out_msg !== 64'hAF11_0000_0000_0042) begin
      errors++;
      $display("FAIL bp_second got=%h want=af11000000000042",
               i_out_msg);
    end
    i_out_msg_ack = 1'b1;
    @(negedge clk);
    i_out_msg_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [63:0] q [$];
    logic [63:0] exp [8];
    int k;
    int acks;
    for (int i = 0; i < 8; i++) begin
      q.push_back({8'hF0, 8'(8'h20 + i), 16'h0,
                   32'hC0DE_0000 | 32'(i)});
      exp[i] = {8'hAF, 8'(8'h20 + i), 16'h0,
                32'hC0DE_0000 | 32'(i)};
    end
    k = 0;
    acks = 0;
    @(negedge clk);
    i_in_msg_rdy = 1'b1;
    i_in_msg     = q[0];
    for (int c = 0; c < 200 && k < 8; c++) begin
      @(negedge clk);
      if (i_in_msg_ack) begin
        acks++;
        if (q.size() > 0) void'(q.pop_front());
      end
      i_in_msg_rdy = (q.size() > 0);
      i_in_msg     = (q.size() > 0) ? q[0] : 64'h0;
      if (i_out_msg_rdy && !i_out_msg_ack) begin
        checks++;
        if (i_out_msg !== exp[k]) begin
          errors++;
          $display("FAIL b2b_%0d got=%h want=%h",
                   k, i_out_msg, exp[k]);
        end
        k++;
        i_out_msg_ack = 1'b1;
      end else begin
        i_out_msg_ack = 1'b0;
      end
    end
    @(negedge clk);
    i_out_msg_ack = 1'b0;
    i_in_msg_rdy  = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (i_in_msg_ack) acks++;
    end
    checks++;
    if (k !== 8 || acks !== 8 || req_count !== 16'd21) begin
      errors++;
      $display("FAIL b2b_totals got=rsp%0d/ack%0d/cnt%0d want=8/8/21",
               k, acks, req_count);
    end
  endtask

  task automatic test_async_reset();
    int rdy_seen;
    bit seen;
    logic [63:0] r;
    int al, rl;
    bit to;
    @(negedge clk);
    i_in_msg     = 64'h1030_0300_0BADF00D;
    i_in_msg_rdy = 1'b1;
    @(negedge clk);
    i_in_msg_rdy = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({i_in_msg_ack, i_out_msg_rdy, busy} !== 3'b000 ||
        {req_count, err_count} !== 24'h0) begin
      errors++;
      $display("FAIL rst_exec got=%b cnt=%h want=000 cnt=0",
               {i_in_msg_ack, i_out_msg_rdy, busy},
               {req_count, err_count});
    end
    @(negedge clk);
    rst = 1'b1;
    rdy_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (i_out_msg_rdy || busy || i_in_msg_ack) rdy_seen++;
    end
    checks++;
    if (rdy_seen !== 0) begin
      errors++;
      $display("FAIL rst_exec_after got=%0d want=0", rdy_seen);
    end
    @(negedge clk);
    i_in_msg     = 64'hF031_0000_12345678;
    i_in_msg_rdy = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (i_in_msg_ack) i_in_msg_rdy = 1'b0;
      seen = i_out_msg_rdy;
    end
    i_in_msg_rdy = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (!seen || i_out_msg_rdy !== 1'b0 ||
        i_out_msg !== 64'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_send got=seen%0d rdy%b msg=%h busy%b want=1/0/0/0",
               seen, i_out_msg_rdy, i_out_msg, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    rdy_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (i_out_msg_rdy || busy) rdy_seen++;
    end
    checks++;
    if (rdy_seen !== 0) begin
      errors++;
      $display("FAIL rst_send_after got=%0d want=0", rdy_seen);
    end
    do_req(64'h2032_0300_0000_0000, r, al, rl, to);
    checks++;
    if (to || r !== 64'hA232_0300_0000_0000 ||
        req_count !== 16'd1) begin
      errors++;
      $display("FAIL rst_table got=%h cnt=%0d want=a232030000000000 cnt=1",
               r, req_count);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_add();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
